// File: rtl/top_bus_pkg.sv
// Shared types and constants for the bus-slave register stage.
package top_bus_pkg;

  // Bus transfer type
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_e;

  // Response codes
  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Register offsets (addr[3:0])
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_LIMIT  = 4'h4;
  localparam logic [3:0] REG_CNT    = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  // CTRL / STATUS bit positions
  localparam int CTRL_ENA    = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;
  localparam int STATUS_WRAP = 0;

  // Response FSM
  typedef enum logic [1:0] {
    RS_OKAY = 2'd0,
    RS_ERR1 = 2'd1,
    RS_ERR2 = 2'd2
  } resp_state_e;

  // Clamp a written LIMIT value to the largest legal limit
  function automatic logic [31:0] sat_limit(input logic [31:0] value, input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/top_bus_cnt.sv
// Wrapping cycle counter: counts while enabled, returns to 0 once it has
// reached the limit, and flags that wrap with a one-cycle pulse.
module top_bus_cnt #(
  parameter int width_p = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               clr,
  input  logic [width_p-1:0] limit,
  output logic [width_p-1:0] cnt,
  output logic               wrap_pulse
);

  // Wrap decision for the current cycle; clear suppresses it
  assign wrap_pulse = ~clr & ena & (cnt >= limit);

  // Counter state: clear beats increment, wrap returns to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || wrap_pulse) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/top_bus_regs.sv
// Bus-slave register stage: decodes AHB-lite style transfers into the
// CTRL/LIMIT/CNT/STATUS register set and owns the wrap counter.
//
// Handshake: an address phase is taken when bus_trans_i is NONSEQ/SEQ and
// bus_ready_o is 1 in that cycle. The next cycle is its data phase: write
// data is sampled there and read data is presented there. OKAY transfers
// never stall; an ERROR holds ready low for one cycle (ERR1) and completes
// with ready high (ERR2), both with resp=1.
module top_bus_regs
  import top_bus_pkg::*;
#(
  parameter int param_p = 10,
  parameter int width_p = $clog2(param_p + 1)
) (
  input  logic               main_clk_i,
  input  logic               main_rst_an_i,
  input  logic [1:0]         bus_trans_i,
  input  logic [31:0]        bus_addr_i,
  input  logic               bus_write_i,
  input  logic [31:0]        bus_wdata_i,
  output logic               bus_ready_o,
  output logic               bus_resp_o,
  output logic [31:0]        bus_rdata_o,
  output logic [width_p-1:0] cnt_o,
  output logic               irq_o,
  output resp_state_e        resp_state_o
);

  trans_e             trans;
  logic               addr_acc;
  logic               addr_err;
  logic               dp_wr;
  logic [3:0]         dp_off;
  logic               wr_ctrl, wr_limit, wr_status;
  logic               ena_q, irq_en_q, wrap_q, wrap_d;
  logic [width_p-1:0] limit_q, limit_new;
  logic               clr, wrap_pulse;
  logic [31:0]        rd_val;
  resp_state_e        state;

  assign trans    = trans_e'(bus_trans_i);
  assign addr_acc = ((trans == TRANS_NONSEQ) || (trans == TRANS_SEQ)) && bus_ready_o;
  assign addr_err = (bus_addr_i[31:4] != 28'd0) || (bus_addr_i[1:0] != 2'd0) ||
                    (bus_write_i && (bus_addr_i[3:0] == REG_CNT));

  // Data-phase write strobes and the values they produce
  assign wr_ctrl   = dp_wr && (dp_off == REG_CTRL);
  assign wr_limit  = dp_wr && (dp_off == REG_LIMIT);
  assign wr_status = dp_wr && (dp_off == REG_STATUS);
  assign limit_new = width_p'(sat_limit(bus_wdata_i, 32'(param_p)));
  assign clr       = wr_ctrl & bus_wdata_i[CTRL_CLR];
  // Hardware wrap set wins over a software W1C in the same cycle
  assign wrap_d    = wrap_pulse | (wrap_q & ~(wr_status & bus_wdata_i[STATUS_WRAP]));

  assign resp_state_o = state;

  top_bus_cnt #(.width_p(width_p)) u_cnt (
    .clk        (main_clk_i),
    .rst_n      (main_rst_an_i),
    .ena        (ena_q),
    .clr        (clr),
    .limit      (limit_q),
    .cnt        (cnt_o),
    .wrap_pulse (wrap_pulse)
  );

  // Remember an accepted, error-free write so its data phase can commit it
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      dp_wr  <= 1'b0;
      dp_off <= 4'h0;
    end else begin
      dp_wr  <= addr_acc && !addr_err && bus_write_i;
      dp_off <= bus_addr_i[3:0];
    end
  end

  // Register file: commits writes at the end of the data phase
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      ena_q    <= 1'b0;
      irq_en_q <= 1'b0;
      limit_q  <= width_p'(param_p);
      wrap_q   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ena_q    <= bus_wdata_i[CTRL_ENA];
        irq_en_q <= bus_wdata_i[CTRL_IRQ_EN];
      end
      if (wr_limit) begin
        limit_q <= limit_new;
      end
      wrap_q <= wrap_d;
      irq_o  <= wrap_q & irq_en_q;
    end
  end

  // Read mux; a write still in its data phase is forwarded from wdata
  always_comb begin
    rd_val = 32'd0;
    case (bus_addr_i[3:0])
      REG_CTRL: begin
        rd_val[CTRL_ENA]    = wr_ctrl ? bus_wdata_i[CTRL_ENA]    : ena_q;
        rd_val[CTRL_IRQ_EN] = wr_ctrl ? bus_wdata_i[CTRL_IRQ_EN] : irq_en_q;
      end
      REG_LIMIT:  rd_val = wr_limit ? 32'(limit_new) : 32'(limit_q);
      REG_CNT:    rd_val = 32'(cnt_o);
      REG_STATUS: rd_val[STATUS_WRAP] = wr_status ? wrap_d : wrap_q;
      default:    rd_val = 32'd0;
    endcase
  end

  // Registered read data: loaded on an accepted read, zeroed on an error
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      bus_rdata_o <= 32'd0;
    end else if (addr_acc) begin
      if (addr_err) begin
        bus_rdata_o <= 32'd0;
      end else if (!bus_write_i) begin
        bus_rdata_o <= rd_val;
      end
    end
  end

  // Response FSM with registered ready/resp
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state       <= RS_OKAY;
      bus_ready_o <= 1'b1;
      bus_resp_o  <= RESP_OKAY;
    end else begin
      case (state)
        RS_ERR1: begin
          state       <= RS_ERR2;
          bus_ready_o <= 1'b1;
          bus_resp_o  <= RESP_ERROR;
        end
        default: begin
          if (addr_acc && addr_err) begin
            state       <= RS_ERR1;
            bus_ready_o <= 1'b0;
            bus_resp_o  <= RESP_ERROR;
          end else begin
            state       <= RS_OKAY;
            bus_ready_o <= 1'b1;
            bus_resp_o  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_bus_regs.sv
// Bench for top_bus_regs: directed scenarios followed by random register
// traffic, all compared every cycle against a transaction-level model.
module tb_top_bus_regs;
  import top_bus_pkg::*;

  localparam int P = 10;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   trans;
  logic [31:0]  addr;
  logic         write;
  logic [31:0]  wdata;
  logic         ready;
  logic         resp;
  logic [31:0]  rdata;
  logic [W-1:0] cnt;
  logic         irq;
  resp_state_e  rs;

  top_bus_regs #(.param_p(P)) dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .bus_trans_i   (trans),
    .bus_addr_i    (addr),
    .bus_write_i   (write),
    .bus_wdata_i   (wdata),
    .bus_ready_o   (ready),
    .bus_resp_o    (resp),
    .bus_rdata_o   (rdata),
    .cnt_o         (cnt),
    .irq_o         (irq),
    .resp_state_o  (rs)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ena, m_irqen, m_wrap, m_irq, m_pend;
  int          m_limit, m_cnt, m_ph;   // m_ph: 0 okay, 1 first error cycle, 2 second
  logic [3:0]  m_poff;
  logic [31:0] m_rdata;

  function automatic bit is_err(input logic [31:0] a, input logic w);
    return (a[31:4] != 28'd0) || (a[1:0] != 2'd0) || (w && (a[3:0] == 4'h8));
  endfunction

  task automatic model_reset();
    m_ena = 0; m_irqen = 0; m_wrap = 0; m_irq = 0; m_pend = 0;
    m_limit = P; m_cnt = 0; m_ph = 0; m_poff = 4'h0; m_rdata = 32'd0;
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_resp"},  32'(resp),  32'd0);
    chk({tag, "_rdata"}, rdata,      32'd0);
    chk({tag, "_cnt"},   32'(cnt),   32'd0);
    chk({tag, "_irq"},   32'(irq),   32'd0);
  endtask

  // One clock: predict from the driven inputs, advance, then compare
  task automatic tick();
    bit acc, err, wc, wl, ws, clr, pulse, nwrap, nena, nirqen, rd;
    int ncnt, nlimit, nph;
    logic [31:0] rv, e;
    acc    = trans[1] && (m_ph != 1);
    err    = acc && is_err(addr, write);
    wc     = m_pend && (m_poff == 4'h0);
    wl     = m_pend && (m_poff == 4'h4);
    ws     = m_pend && (m_poff == 4'hC);
    clr    = wc && wdata[2];
    pulse  = !clr && m_ena && (m_cnt >= m_limit);
    ncnt   = (clr || pulse) ? 0 : (m_ena ? m_cnt + 1 : m_cnt);
    nwrap  = pulse || (m_wrap && !(ws && wdata[0]));
    nena   = wc ? wdata[0] : m_ena;
    nirqen = wc ? wdata[1] : m_irqen;
    nlimit = wl ? ((wdata > 32'(P)) ? P : int'(wdata)) : m_limit;
    rd     = acc && !err && !write;
    rv     = 32'd0;
    case (addr[3:0])
      4'h0: rv = {30'd0, nirqen, nena};
      4'h4: rv = 32'(nlimit);
      4'h8: rv = 32'(m_cnt);
      4'hC: rv = {31'd0, (ws ? nwrap : m_wrap)};
      default: rv = 32'd0;
    endcase
    nph = err ? 1 : ((m_ph == 1) ? 2 : 0);
    @(posedge clk);
    m_irq   = m_wrap && m_irqen;
    m_cnt   = ncnt;
    m_wrap  = nwrap;
    m_ena   = nena;
    m_irqen = nirqen;
    m_limit = nlimit;
    m_ph    = nph;
    m_pend  = acc && !err && write;
    m_poff  = addr[3:0];
    if (acc) m_rdata = err ? 32'd0 : (rd ? rv : m_rdata);
    if (rd) exp_q.push_back(rv);
    #1;
    chk("ready", 32'(ready), 32'(m_ph != 1));
    chk("resp",  32'(resp),  32'(m_ph != 0));
    chk("state", 32'(rs),    32'(m_ph));
    chk("cnt",   32'(cnt),   32'(m_cnt));
    chk("irq",   32'(irq),   32'(m_irq));
    chk("rdata_hold", rdata, m_rdata);
    if (rd) begin
      e = exp_q.pop_front();
      chk("read_data", rdata, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd_got);
    trans = 2'd2; addr = a; write = wr;
    tick();
    trans = 2'd0; wdata = d; rd_got = rdata;
    tick();
  endtask

  task automatic wait_cnt(input int target);
    int k;
    k = 0;
    while ((m_cnt != target) && (k < 40)) begin
      tick();
      k++;
    end
    chk("wait_cnt", 32'(cnt), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    trans = 2'd0; addr = 32'd0; write = 1'b0; wdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Reset LIMIT value
    xfer(0, 32'h4, 32'd0, r);
    chk("limit_reset_read", r, 32'd10);

    // Counting with wrap and interrupt
    xfer(1, 32'h4, 32'd3, r);
    xfer(1, 32'h0, 32'd3, r);
    repeat (10) tick();
    xfer(1, 32'hC, 32'd1, r);
    repeat (3) tick();

    // Error responses
    xfer(0, 32'h10, 32'd0, r);
    xfer(1, 32'h8, 32'd5, r);
    xfer(0, 32'h2, 32'd0, r);
    tick();

    // clr beats increment and does not set wrap
    xfer(1, 32'h0, 32'h4, r);
    xfer(1, 32'h4, 32'd10, r);
    xfer(1, 32'hC, 32'd1, r);
    xfer(1, 32'h0, 32'h1, r);
    wait_cnt(1);
    xfer(1, 32'h0, 32'h5, r);
    chk("clr_cnt", 32'(cnt), 32'd0);
    xfer(0, 32'hC, 32'd0, r);
    chk("clr_no_wrap", r, 32'd0);

    // W1C in the wrap cycle loses to the hardware set
    wait_cnt(9);
    xfer(1, 32'hC, 32'd1, r);
    xfer(0, 32'hC, 32'd0, r);
    chk("w1c_vs_wrap", r, 32'd1);

    // LIMIT saturation and LIMIT=0
    xfer(1, 32'h4, 32'd15, r);
    xfer(0, 32'h4, 32'd0, r);
    chk("limit_sat", r, 32'd10);
    xfer(1, 32'h4, 32'd0, r);
    repeat (4) tick();
    chk("limit0_cnt", 32'(cnt), 32'd0);
    xfer(0, 32'hC, 32'd0, r);
    chk("limit0_wrap", r, 32'd1);

    // Pipelined: write CTRL, forwarded read, BUSY, error, reset in ERR1
    trans = 2'd2; addr = 32'h0; write = 1'b1;
    tick();
    trans = 2'd3; addr = 32'h0; write = 1'b0; wdata = 32'h3;
    tick();
    chk("fwd_rdata", rdata, 32'h3);
    trans = 2'd1; addr = 32'h8; write = 1'b1;
    tick();
    chk("busy_okay", {30'd0, ready, resp}, 32'h2);
    trans = 2'd2; addr = 32'h20; write = 1'b0;
    tick();
    chk("err1_ready", 32'(ready), 32'd0);
    trans = 2'd0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();

    // Random register traffic
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0: xfer(1, 32'h0, 32'($urandom_range(0, 7)), r);
        1: xfer(1, 32'h4, 32'($urandom_range(0, 15)), r);
        2: xfer(1, 32'hC, 32'($urandom_range(0, 1)), r);
        3: begin
          a = 32'($urandom_range(0, 3)) << 2;
          xfer(0, a, 32'd0, r);
        end
        4: begin
          case ($urandom_range(0, 2))
            0: a = (32'($urandom_range(1, 255)) << 4) | (32'($urandom_range(0, 3)) << 2);
            1: a = (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(1, 3));
            default: a = 32'h8;
          endcase
          xfer((a == 32'h8) ? 1'b1 : 1'($urandom_range(0, 1)), a, $urandom, r);
        end
        default: repeat ($urandom_range(1, 4)) tick();
      endcase
    end
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
